// File: rtl/codec_pkg.sv
// Shared constants, FSM state type and width helpers for the WM8731 clock
// generator and the I2S serializer that follows it.
package codec_pkg;

    localparam int MCLK_HALF_DEF = 2;
    localparam int BCLK_HALF_DEF = 8;
    localparam int SLOT_BITS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int bit_idx_w(input int slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/codec_half_div.sv
// Modulo-N counter with clear/enable; flips a toggle register each time the
// count wraps, giving a square wave with a half-period of N enabled cycles.
module codec_half_div
    import codec_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    output logic                tog,
    output logic                wrap_next,
    output logic [cnt_w(N)-1:0] cnt
);

    localparam int             CW   = cnt_w(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
                tog <= ~tog;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign wrap_next = (cnt == LAST);

endmodule

// File: rtl/codec_clk_gen.sv
// WM8731 clock generator: free-running Mclk plus Bclk/Lrclk with pre-edge
// strobes and bit index, stopping only on a frame boundary after Enable drops.
module codec_clk_gen
    import codec_pkg::*;
#(
    parameter int MCLK_HALF = MCLK_HALF_DEF,
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            Enable,
    output logic                            Mclk,
    output logic                            Bclk,
    output logic                            Lrclk,
    output logic                            BclkRisePre,
    output logic                            BclkFallPre,
    output logic                            FramePre,
    output logic [bit_idx_w(SLOT_BITS)-1:0] BitIdx,
    output logic                            Active
);

    localparam int            BW       = bit_idx_w(SLOT_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_BITS - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic                          running;
    logic                          bclk_wrap;
    logic                          mclk_wrap;
    logic [cnt_w(MCLK_HALF)-1:0]   mclk_cnt;
    logic [cnt_w(BCLK_HALF)-1:0]   bclk_cnt;
    logic [BW-1:0]                 bit_idx_q;
    logic                          lrclk_q;
    logic                          cnt_unused;

    assign running = (state_q != IDLE);

    codec_half_div #(.N(MCLK_HALF)) u_mclk_div (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .clr       (1'b0),
        .en        (1'b1),
        .tog       (Mclk),
        .wrap_next (mclk_wrap),
        .cnt       (mclk_cnt)
    );

    // Held cleared in IDLE so the first RUN cycle always starts at count 0.
    codec_half_div #(.N(BCLK_HALF)) u_bclk_div (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .clr       (!running),
        .en        (running),
        .tog       (Bclk),
        .wrap_next (bclk_wrap),
        .cnt       (bclk_cnt)
    );

    assign cnt_unused = ^{mclk_wrap, mclk_cnt, bclk_cnt};

    assign BclkRisePre = running & bclk_wrap & ~Bclk;
    assign BclkFallPre = running & bclk_wrap & Bclk;
    assign FramePre    = BclkFallPre & (bit_idx_q == LAST_BIT) & lrclk_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A re-asserted Enable wins over the frame boundary so the clocks never stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Enable) state_d = RUN;
            RUN:     if (!Enable) state_d = DRAIN;
            DRAIN: begin
                if (Enable) begin
                    state_d = RUN;
                end else if (FramePre) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Leaving DRAIN coincides with the last Bclk fall of a right slot, so the
    // natural wrap already lands bit index and Lrclk at zero.
    always_ff @(posedge Clk) begin
        if (!Rst_n || !running) begin
            bit_idx_q <= '0;
            lrclk_q   <= 1'b0;
        end else if (BclkFallPre) begin
            if (bit_idx_q == LAST_BIT) begin
                bit_idx_q <= '0;
                lrclk_q   <= ~lrclk_q;
            end else begin
                bit_idx_q <= bit_idx_q + BW'(1);
            end
        end
    end

    assign BitIdx = bit_idx_q;
    assign Lrclk  = lrclk_q;
    assign Active = running;

endmodule

// File: tb/tb_codec_clk_gen.sv
// Self-checking bench for codec_clk_gen: directed scenarios plus random
// Enable/reset activity, compared every cycle against an arithmetic timing model.
module tb_codec_clk_gen;

    localparam int MH    = 2;
    localparam int BH    = 8;
    localparam int SB    = 32;
    localparam int BIT_P = 2 * BH;
    localparam int SLOT  = SB * BIT_P;
    localparam int FRAME = 2 * SLOT;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       mclk;
    logic       bclk;
    logic       lrclk;
    logic       rise_pre;
    logic       fall_pre;
    logic       frame_pre;
    logic [4:0] bit_idx;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    codec_clk_gen #(
        .MCLK_HALF (MH),
        .BCLK_HALF (BH),
        .SLOT_BITS (SB)
    ) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .Enable      (enable),
        .Mclk        (mclk),
        .Bclk        (bclk),
        .Lrclk       (lrclk),
        .BclkRisePre (rise_pre),
        .BclkFallPre (fall_pre),
        .FramePre    (frame_pre),
        .BitIdx      (bit_idx),
        .Active      (active)
    );

    always #10 clk = ~clk;

    // Reference model: edges since reset for Mclk, and t = cycles since the
    // first RUN cycle; every codec output is plain arithmetic on t.
    int mc_n    = 0;
    int t       = 0;
    bit m_act   = 1'b0;
    bit m_drain = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mc_n    = 0;
            t       = 0;
            m_act   = 1'b0;
            m_drain = 1'b0;
        end else begin
            mc_n++;
            if (!m_act) begin
                if (enable) begin
                    m_act   = 1'b1;
                    m_drain = 1'b0;
                    t       = 0;
                end
            end else if (m_drain && !enable && (t % FRAME) == FRAME - 1) begin
                m_act = 1'b0;
                t     = 0;
            end else begin
                t++;
                m_drain = !enable;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int e_mclk, e_bclk, e_lr, e_idx, e_rise, e_fall, e_frame, e_act, ph;
        if (chk_on) begin
            e_mclk = (mc_n / MH) % 2;
            if (m_act) begin
                ph      = t % BIT_P;
                e_act   = 1;
                e_bclk  = (ph >= BH) ? 1 : 0;
                e_rise  = (ph == BH - 1) ? 1 : 0;
                e_fall  = (ph == BIT_P - 1) ? 1 : 0;
                e_idx   = (t / BIT_P) % SB;
                e_lr    = (t / SLOT) % 2;
                e_frame = ((t % FRAME) == FRAME - 1) ? 1 : 0;
            end else begin
                e_act   = 0;
                e_bclk  = 0;
                e_rise  = 0;
                e_fall  = 0;
                e_idx   = 0;
                e_lr    = 0;
                e_frame = 0;
            end
            check_eq("mclk",      32'(mclk),      e_mclk);
            check_eq("active",    32'(active),    e_act);
            check_eq("bclk",      32'(bclk),      e_bclk);
            check_eq("lrclk",     32'(lrclk),     e_lr);
            check_eq("bit_idx",   32'(bit_idx),   e_idx);
            check_eq("rise_pre",  32'(rise_pre),  e_rise);
            check_eq("fall_pre",  32'(fall_pre),  e_fall);
            check_eq("frame_pre", 32'(frame_pre), e_frame);
        end
    end

    task automatic drive(input bit en, input int cycles);
        @(negedge clk);
        enable = en;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int len;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: only Mclk moves.
        drive(1'b0, 2000);
        // Continuous run across several frames.
        drive(1'b1, 3000);
        drive(1'b0, 2100);
        // Stop request mid-frame, then drain to the boundary.
        drive(1'b1, 301);
        drive(1'b0, 1500);
        // Stop request withdrawn during drain.
        drive(1'b1, 301);
        drive(1'b0, 400);
        drive(1'b1, 1500);
        // Reset while running, restart with Enable held.
        drive(1'b1, 600);
        pulse_reset(1);
        drive(1'b1, 2100);
        drive(1'b0, 2100);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else begin
                len = (r < 3) ? $urandom_range(1, 6) : $urandom_range(1, 1200);
                drive(1'(($urandom_range(0, 1))), len);
            end
        end
        drive(1'b0, 2100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
